// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller for a DDS: steps K from k_start to k_stop by k_step,
// holding each word for a programmable dwell; single-shot or continuous repeat.
module dds_sweep_ctrl #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [31:0]        k_start,
  input  logic [31:0]        k_stop,
  input  logic [31:0]        k_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mode,
  input  logic [10:0]        p_in,
  output logic [31:0]        K,
  output logic [10:0]        P,
  output logic               busy,
  output logic               step_tick,
  output logic               sweep_done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {StIdle, StDwell, StDone} state_e;

  state_e               state_q, state_d;
  logic [31:0]          k_q, k_d;
  logic [10:0]          p_q, p_d;
  logic [31:0]          ks_q, ks_d;
  logic [31:0]          kp_q, kp_d;
  logic [31:0]          kstep_q, kstep_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 mode_q, mode_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 tick_q, tick_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [32:0]          next_sum;
  logic                 cfg_ok;

  // Counter counts down to zero, so a dwell of 0 or 1 both give a one-cycle hold.
  function automatic logic [DWELL_W-1:0] reload(input logic [DWELL_W-1:0] dw);
    return (dw == '0) ? '0 : dw - 1'b1;
  endfunction

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    p_d      = p_in;
    ks_d     = ks_q;
    kp_d     = kp_q;
    kstep_d  = kstep_q;
    dwell_d  = dwell_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    next_sum = {1'b0, k_q} + {1'b0, kstep_q};
    cfg_ok   = (k_step != 32'd0) && (k_start <= k_stop);

    case (state_q)
      StIdle: begin
        // stop outranks start, and also suppresses any cfg_err
        if (start && !stop) begin
          if (cfg_ok) begin
            ks_d    = k_start;
            kp_d    = k_stop;
            kstep_d = k_step;
            dwell_d = dwell;
            mode_d  = mode;
            k_d     = k_start;
            cnt_d   = reload(dwell);
            tick_d  = 1'b1;
            state_d = StDwell;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StDwell: begin
        if (stop) begin
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!next_sum[32] && (next_sum[31:0] <= kp_q)) begin
          k_d    = next_sum[31:0];
          cnt_d  = reload(dwell_q);
          tick_d = 1'b1;
        end else if (mode_q) begin
          k_d    = ks_q;
          cnt_d  = reload(dwell_q);
          tick_d = 1'b1;
        end else begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      p_q     <= '0;
      ks_q    <= '0;
      kp_q    <= '0;
      kstep_q <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      p_q     <= p_d;
      ks_q    <= ks_d;
      kp_q    <= kp_d;
      kstep_q <= kstep_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign K          = k_q;
  assign P          = p_q;
  assign busy       = busy_q;
  assign step_tick  = tick_q;
  assign sweep_done = done_q;
  assign cfg_err    = err_q;

endmodule
